// File: rtl/uart_tx_frame.sv
// uart_tx_frame: oversampled UART transmitter.
// Accepts one parallel word per Data_Valid handshake while idle and shifts it
// out as start / data (LSB first) / optional parity / stop, each bit held for
// the prescale value latched at acceptance. TX_OUT and busy come from flops.
module uart_tx_frame #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      Data_Valid,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      TX_OUT,
   output logic                      busy
);

   localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } txState_t;

   txState_t                  r_state;
   txState_t                  w_nextState;

   logic [DATA_WIDTH-1:0]     r_data;
   logic                      r_parEn;
   logic                      r_parityBit;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [PRESCALE_WIDTH-1:0] r_edgeCnt;
   logic [BIT_CNT_WIDTH-1:0]  r_bitCnt;
   logic                      r_txOut;
   logic                      r_busy;

   logic [PRESCALE_WIDTH-1:0] w_lastCnt;
   logic                      w_bitEnd;
   logic                      w_lastBit;
   logic                      w_accept;
   logic [BIT_CNT_WIDTH-1:0]  w_nextBitCnt;
   logic                      w_txNext;
   logic                      w_busyNext;

   // A latched prescale of zero behaves as a one-cycle bit period.
   assign w_lastCnt = (r_prescale == '0) ? '0 : (r_prescale - PRESCALE_WIDTH'(1));
   assign w_bitEnd  = (r_state != IDLE) && (r_edgeCnt == w_lastCnt);
   assign w_lastBit = (r_bitCnt == LAST_BIT);
   assign w_accept  = (r_state == IDLE) && Data_Valid;

   // State register: reset forces IDLE, aborting any frame in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: every non-idle state advances only at the end of its bit period.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (Data_Valid) begin
               w_nextState = START;
            end
         end
         START: begin
            if (w_bitEnd) begin
               w_nextState = DATA;
            end
         end
         DATA: begin
            if (w_bitEnd && w_lastBit) begin
               w_nextState = r_parEn ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (w_bitEnd) begin
               w_nextState = STOP;
            end
         end
         STOP: begin
            if (w_bitEnd) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Data bit index for the coming cycle: steps at each data bit end, wraps to 0 after the last.
   always_comb begin
      w_nextBitCnt = r_bitCnt;
      if (r_state == IDLE) begin
         w_nextBitCnt = '0;
      end else if ((r_state == DATA) && w_bitEnd) begin
         w_nextBitCnt = w_lastBit ? '0 : (r_bitCnt + BIT_CNT_WIDTH'(1));
      end
   end

   // Output decode from the upcoming state, so the registered line changes together with the state.
   always_comb begin
      w_txNext   = 1'b1;
      w_busyNext = 1'b0;
      case (w_nextState)
         IDLE: begin
            w_txNext   = 1'b1;
            w_busyNext = 1'b0;
         end
         START: begin
            w_txNext   = 1'b0;
            w_busyNext = 1'b1;
         end
         DATA: begin
            w_txNext   = r_data[w_nextBitCnt];
            w_busyNext = 1'b1;
         end
         PARITY: begin
            w_txNext   = r_parityBit;
            w_busyNext = 1'b1;
         end
         STOP: begin
            w_txNext   = 1'b1;
            w_busyNext = 1'b1;
         end
         default: begin
            w_txNext   = 1'b1;
            w_busyNext = 1'b0;
         end
      endcase
   end

   // Output flops keep TX_OUT and busy glitch-free; reset returns the line to idle-high.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_txOut <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_txOut <= w_txNext;
         r_busy  <= w_busyNext;
      end
   end

   // Bit timing counters and the frame holding registers captured on acceptance.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_edgeCnt   <= '0;
         r_bitCnt    <= '0;
         r_data      <= '0;
         r_parEn     <= 1'b0;
         r_parityBit <= 1'b0;
         r_prescale  <= '0;
      end else begin
         if ((r_state == IDLE) || w_bitEnd) begin
            r_edgeCnt <= '0;
         end else begin
            r_edgeCnt <= r_edgeCnt + PRESCALE_WIDTH'(1);
         end
         r_bitCnt <= w_nextBitCnt;
         if (w_accept) begin
            r_data      <= P_DATA;
            r_parEn     <= PAR_EN;
            r_parityBit <= (^P_DATA) ^ PAR_TYP;
            r_prescale  <= prescale;
         end
      end
   end

   assign TX_OUT = r_txOut;
   assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame.
// The reference model expands each requested frame into the expected
// per-cycle TX_OUT waveform (a queue of bits), derived from the frame format
// and bit period; the DUT is compared cycle by cycle on the falling edge.
module tb_uart_tx_frame;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] P_DATA = '0;
   logic       Data_Valid = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] prescale = '0;
   logic       TX_OUT;
   logic       busy;

   int totalChecks = 0;
   int badChecks   = 0;
   bit expQ[$];

   uart_tx_frame #(
      .DATA_WIDTH     (8),
      .PRESCALE_WIDTH (6)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .prescale   (prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   // 100 MHz-style free-running clock.
   always #5 CLK = ~CLK;

   // Watchdog so the run always ends even if the sequence stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: run exceeded time limit, got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h want %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Reference model: frame = start 0, data LSB first, optional parity, stop 1,
   // every bit repeated for the effective bit period.
   task automatic buildExpected(input logic [7:0] data, input logic pe, input logic pt,
                                input logic [5:0] pre);
      int p;
      bit frameBits[$];
      p = (pre == 6'd0) ? 1 : int'(pre);
      expQ.delete();
      frameBits.push_back(1'b0);
      for (int i = 0; i < 8; i++) frameBits.push_back(data[i]);
      if (pe) begin
         // even parity: bit makes the total count of ones even; odd inverts it
         frameBits.push_back((($countones(data) % 2) == 1) ^ pt);
      end
      frameBits.push_back(1'b1);
      foreach (frameBits[j]) begin
         for (int k = 0; k < p; k++) expQ.push_back(frameBits[j]);
      end
   endtask

   // Idle line check for n cycles (advances to the next falling edge first).
   task automatic checkIdle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         checkOutput({tag, " idle tx"}, TX_OUT, 1);
         checkOutput({tag, " idle busy"}, busy, 0);
      end
   endtask

   // Issue a request at the current falling edge and check the whole frame.
   // mode 0: single-cycle pulse; mode 1: disturb inputs and re-request 0x3C
   // while busy; mode 2: hold Data_Valid with the next frame's inputs.
   // Ends on the single idle cycle after the stop bit.
   task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic pt,
                                input logic [5:0] pre, input int mode,
                                input logic [7:0] nd, input logic npe, input logic npt,
                                input logic [5:0] npre, input string tag);
      int n;
      P_DATA     = data;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      prescale   = pre;
      Data_Valid = 1'b1;
      buildExpected(data, pe, pt, pre);
      n = expQ.size();
      @(negedge CLK);
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, " tx"}, TX_OUT, expQ[i]);
         checkOutput({tag, " busy"}, busy, 1);
         case (mode)
            1: begin
               P_DATA     = 8'h3C;
               PAR_EN     = 1'($urandom);
               PAR_TYP    = ~PAR_TYP;
               prescale   = 6'($urandom);
               Data_Valid = (i == n / 2) || ($urandom_range(0, 3) == 0);
            end
            2: begin
               P_DATA     = nd;
               PAR_EN     = npe;
               PAR_TYP    = npt;
               prescale   = npre;
               Data_Valid = 1'b1;
            end
            default: begin
               Data_Valid = 1'b0;
            end
         endcase
         @(negedge CLK);
      end
      checkOutput({tag, " gap tx"}, TX_OUT, 1);
      checkOutput({tag, " gap busy"}, busy, 0);
      if (mode != 2) Data_Valid = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      logic       rpe;
      logic       rpt;
      logic [5:0] rpre;
      int         rmode;

      $display("[TB] uart_tx_frame bench start");

      // Reset held for three cycles, then a quiet idle line.
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      checkOutput("reset tx", TX_OUT, 1);
      checkOutput("reset busy", busy, 0);
      RST = 1'b0;
      checkIdle(20, "post-reset");

      // 8N1 frame at prescale 8.
      applyStimulus(8'hA5, 1'b0, 1'b0, 6'd8, 0, 8'h00, 1'b0, 1'b0, 6'd0, "8N1 A5");
      checkIdle(2, "8N1 A5");

      // Parity frames, even then odd, prescale 16.
      applyStimulus(8'hA5, 1'b1, 1'b0, 6'd16, 0, 8'h00, 1'b0, 1'b0, 6'd0, "8E1 A5");
      checkIdle(1, "8E1 A5");
      applyStimulus(8'hA5, 1'b1, 1'b1, 6'd16, 0, 8'h00, 1'b0, 1'b0, 6'd0, "8O1 A5");
      checkIdle(1, "8O1 A5");

      // Requests and input changes while busy must not disturb the frame.
      applyStimulus(8'h96, 1'b1, 1'b0, 6'd4, 1, 8'h00, 1'b0, 1'b0, 6'd0, "busy-reject");
      checkIdle(3, "busy-reject");

      // Held request is taken in the single idle cycle after the stop bit.
      applyStimulus(8'h81, 1'b0, 1'b0, 6'd5, 2, 8'h3C, 1'b0, 1'b0, 6'd5, "hold first");
      applyStimulus(8'h3C, 1'b0, 1'b0, 6'd5, 0, 8'h00, 1'b0, 1'b0, 6'd0, "hold 3C");
      checkIdle(2, "hold 3C");

      // Mid-frame reset during data bit 4 of 0xFF at prescale 8.
      P_DATA     = 8'hFF;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      prescale   = 6'd8;
      Data_Valid = 1'b1;
      buildExpected(8'hFF, 1'b0, 1'b0, 6'd8);
      @(negedge CLK);
      Data_Valid = 1'b0;
      for (int i = 0; i < 44; i++) begin
         checkOutput("pre-abort tx", TX_OUT, expQ[i]);
         checkOutput("pre-abort busy", busy, 1);
         @(negedge CLK);
      end
      RST = 1'b1;
      @(negedge CLK);
      checkOutput("abort tx", TX_OUT, 1);
      checkOutput("abort busy", busy, 0);
      RST = 1'b0;
      checkIdle(3, "after-abort");
      applyStimulus(8'hFF, 1'b0, 1'b0, 6'd8, 0, 8'h00, 1'b0, 1'b0, 6'd0, "after-abort FF");
      checkIdle(1, "after-abort FF");

      // Prescale boundaries: 1, 0 (treated as 1) and 63.
      applyStimulus(8'h55, 1'b1, 1'b0, 6'd1, 0, 8'h00, 1'b0, 1'b0, 6'd0, "pre1 55");
      checkIdle(1, "pre1 55");
      applyStimulus(8'h55, 1'b1, 1'b0, 6'd0, 0, 8'h00, 1'b0, 1'b0, 6'd0, "pre0 55");
      checkIdle(1, "pre0 55");
      rd  = 8'($urandom);
      rpe = 1'($urandom);
      applyStimulus(rd, rpe, 1'b1, 6'd63, 0, 8'h00, 1'b0, 1'b0, 6'd0, "pre63");
      checkIdle(1, "pre63");

      // Randomized frames with random settings and random disturbance.
      for (int f = 0; f < 15; f++) begin
         rd    = 8'($urandom);
         rpe   = 1'($urandom);
         rpt   = 1'($urandom);
         rpre  = 6'($urandom_range(0, 12));
         rmode = $urandom_range(0, 1);
         applyStimulus(rd, rpe, rpt, rpre, rmode, 8'h00, 1'b0, 1'b0, 6'd0, "random");
         checkIdle(1, "random");
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial UART transmitter, the transmit-side counterpart of the system's oversampled UART receiver.
- Runs on the same oversampling clock as the receiver.
- Converts one parallel byte per handshake into a start / data / optional-parity / stop frame.
- Each bit is held for `prescale` clock cycles, so both ends share one clock and one prescale setting.
- Sits between the TX-side FIFO/synchronizer (source of bytes) and the serial line pin.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input (bit-period counter width).

Ports:
- CLK  input  1  system/oversampling clock; all logic on rising edge.
- RST  input  1  reset; synchronous, active-high.
- P_DATA  input  DATA_WIDTH  byte to transmit; sampled only on acceptance.
- Data_Valid  input  1  request to send P_DATA; accepted only when busy=0.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on acceptance.
- prescale  input  PRESCALE_WIDTH  bit period in CLK cycles; sampled on acceptance.
- TX_OUT  output  1  serial line, registered; idle high.
- busy  output  1  registered; high while a frame is in flight.

Behaviour:
- Clocking and reset:
  - One clock, CLK.
  - Reset RST is synchronous and active-high.
  - On a CLK edge with RST=1: state=IDLE, TX_OUT=1, busy=0, all counters and holding registers = 0.
  - Reset mid-frame aborts the frame immediately; TX_OUT=1 from the next edge. No partial-frame resumption.
- Acceptance:
  - Data_Valid=1 is accepted on any edge where the state is IDLE and RST=0.
  - On acceptance, latch P_DATA, PAR_EN, PAR_TYP and prescale, and compute the parity bit: PAR_TYP=0 gives XOR of the data bits; PAR_TYP=1 gives its inverse.
  - Input changes after acceptance have no effect on the current frame.
  - Data_Valid while busy=1 is ignored (dropped); the source must hold or retry.
- Latency: TX_OUT drives the start bit (0) and busy=1 starting the edge after acceptance.
- FSM states:
  - IDLE: TX_OUT=1, busy=0.
  - START: TX_OUT=0.
  - DATA: TX_OUT = data[bit_cnt], LSB first.
  - PARITY: TX_OUT = parity bit.
  - STOP: TX_OUT=1.
- Bit timing:
  - edge_cnt (PRESCALE_WIDTH bits) counts 0..P-1 within each bit, where P = latched prescale.
  - A latched prescale of 0 is treated as P=1.
  - When edge_cnt=P-1 the bit ends: edge_cnt wraps to 0 and the state/bit advances.
- Transitions:
  - START to DATA at bit end.
  - DATA advances bit_cnt (3 bits for width 8) at each bit end. After bit DATA_WIDTH-1: to PARITY if PAR_EN latched, else to STOP.
  - PARITY to STOP at bit end.
  - STOP to IDLE at bit end.
- Frame length: (10 + PAR_EN) × P cycles of busy=1.
- Back-to-back frames:
  - busy=0 for at least one cycle (IDLE) between frames.
  - A Data_Valid held high is accepted in that IDLE cycle; the next start bit follows one cycle later.
  - Inter-frame high time on TX_OUT is therefore exactly 1 cycle beyond the stop bit.
- Outputs are glitch-free: TX_OUT and busy come directly from flops.

Test Plan:
- Reset and idle: hold RST=1 for 3 cycles, then release with Data_Valid=0 → TX_OUT=1 and busy=0 indefinitely.
- 8N1 frame: prescale=8, PAR_EN=0, P_DATA=0xA5, 1-cycle Data_Valid pulse →
  - TX_OUT = 0, 1,0,1,0,0,1,0,1, 1 (each bit held 8 cycles), starting the cycle after the pulse;
  - busy high for exactly 80 cycles.
- Parity frames: prescale=16, PAR_EN=1, P_DATA=0xA5 →
  - PAR_TYP=0 gives parity bit 0; PAR_TYP=1 gives parity bit 1;
  - busy high for 176 cycles.
- Busy rejection and input stability:
  - During a frame, pulse Data_Valid with P_DATA=0x3C and toggle PAR_TYP/prescale → current frame unchanged, 0x3C never transmitted.
  - Holding Data_Valid high with 0x3C → sent after exactly one idle cycle.
- Mid-frame reset: assert RST during data bit 4 of 0xFF at prescale=8 → next edge TX_OUT=1, busy=0. A following request sends a complete, correct frame.
- Prescale boundaries:
  - prescale=1 with 0x55, PAR_EN=1, even → 11 one-cycle bits 0,1,0,1,0,1,0,1,0,0,1.
  - prescale=0 → identical to prescale=1.
  - prescale=63 → every bit lasts 63 cycles.
